cpu_mem_model: RTL and testbench

Parametrised instruction/data memory model for the CPU bench, replacing hand-coded case-statement instruction ROMs and print-only data monitors. Provides a word-addressed backing store with an instruction read port, a byte-enabled data read/write port, a bench loader port, configurable read latency, and a halt mailbox. Sits between `cpu_top`'s `inst_*`/`data_*` ports and the bench; the bench polls `halt`/`err` to end a run.

---
 rtl/cpu_mem_model_if.sv | 28 ++
 rtl/cpu_mem_model.sv | 106 ++++++++++
 tb/tb_cpu_mem_model.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_model_if.sv
// Bus bundle between the CPU (or bench) and the memory model: fetch, load/store,
// loader and status/mailbox signals.
interface cpu_mem_model_if;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_we;
    logic [31:0] data_rdata;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        halt;
    logic [31:0] halt_code;
    logic        err;
    logic [31:0] err_addr;
    logic [15:0] wr_count;

    modport master (
        output inst_addr, data_addr, data_wdata, data_we, load_en, load_addr, load_data,
        input  inst_rdata, data_rdata, halt, halt_code, err, err_addr, wr_count
    );

    modport slave (
        input  inst_addr, data_addr, data_wdata, data_we, load_en, load_addr, load_data,
        output inst_rdata, data_rdata, halt, halt_code, err, err_addr, wr_count
    );
endinterface

// File: rtl/cpu_mem_model.sv
// Word-addressed instruction/data memory with byte-enabled stores, bench loader,
// pipelined read latency, halt mailbox and sticky access-error capture.
module cpu_mem_model #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_FFF0
) (
    input  logic              clk,
    input  logic              reset,
    cpu_mem_model_if.slave    bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && (off[31:AW+2] == '0);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[AW+1:2];
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    logic [READ_LATENCY-1:0][31:0] i_pipe, d_pipe;
    logic          halt_r, err_r;
    logic [31:0]   halt_code_r, err_addr_r;
    logic [15:0]   wr_count_r;

    logic          i_ok, d_ok, l_ok;
    logic [AW-1:0] i_idx, d_idx, l_idx;
    logic          store, halt_hit, st_wr, st_err, i_err;

    assign i_ok  = in_range(bus.inst_addr);
    assign d_ok  = in_range(bus.data_addr);
    assign l_ok  = in_range(bus.load_addr);
    assign i_idx = word_idx(bus.inst_addr);
    assign d_idx = word_idx(bus.data_addr);
    assign l_idx = word_idx(bus.load_addr);

    // Once halted, the data port becomes read-only until reset.
    assign store    = (|bus.data_we) && !halt_r && !reset;
    assign halt_hit = store && (bus.data_addr == HALT_ADDR);
    assign st_wr    = store && !halt_hit && d_ok;
    assign st_err   = store && !halt_hit && !d_ok;
    assign i_err    = |bus.inst_addr[1:0];

    // Loader goes first so the data store's enabled lanes override it on a collision.
    always_ff @(posedge clk) begin
        if (bus.load_en && l_ok)
            mem[l_idx] <= bus.load_data;
        if (st_wr)
            for (int b = 0; b < 4; b++)
                if (bus.data_we[b])
                    mem[d_idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
    end

    // Reads sample the pre-write array contents, giving read-before-write.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_pipe <= '0;
            d_pipe <= '0;
        end else begin
            i_pipe[0] <= i_ok ? mem[i_idx] : 32'h0;
            d_pipe[0] <= d_ok ? mem[d_idx] : 32'h0;
            for (int s = 1; s < READ_LATENCY; s++) begin
                i_pipe[s] <= i_pipe[s-1];
                d_pipe[s] <= d_pipe[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halt_r      <= 1'b0;
            halt_code_r <= '0;
            err_r       <= 1'b0;
            err_addr_r  <= '0;
            wr_count_r  <= '0;
        end else begin
            if (halt_hit) begin
                halt_r      <= 1'b1;
                halt_code_r <= bus.data_wdata;
            end
            if (st_wr && wr_count_r != 16'hFFFF)
                wr_count_r <= wr_count_r + 16'd1;
            // Data-side error takes priority for the recorded address.
            if (!err_r && (st_err || i_err)) begin
                err_r      <= 1'b1;
                err_addr_r <= st_err ? bus.data_addr : bus.inst_addr;
            end
        end
    end

    assign bus.inst_rdata = i_pipe[READ_LATENCY-1];
    assign bus.data_rdata = d_pipe[READ_LATENCY-1];
    assign bus.halt       = halt_r;
    assign bus.halt_code  = halt_code_r;
    assign bus.err        = err_r;
    assign bus.err_addr   = err_addr_r;
    assign bus.wr_count   = wr_count_r;
endmodule

// File: tb/tb_cpu_mem_model.sv
// Bench for cpu_mem_model: three instances (latency 1, 3, 4) share one directed
// stimulus stream and are checked every cycle against a behavioural memory model.
module tb_cpu_mem_model;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;
    localparam logic [31:0] HALTA = 32'h0000_FFF0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0] inst_addr, data_addr, data_wdata, load_addr, load_data;
    logic [3:0]  data_we;
    logic        load_en;

    logic [2:0][31:0] inst_rd, data_rd, hcode, eaddr;
    logic [2:0][15:0] wcnt;
    logic [2:0]       halt_o, err_o;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        cpu_mem_model_if b();
        assign b.inst_addr  = inst_addr;
        assign b.data_addr  = data_addr;
        assign b.data_wdata = data_wdata;
        assign b.data_we    = data_we;
        assign b.load_en    = load_en;
        assign b.load_addr  = load_addr;
        assign b.load_data  = load_data;
        assign inst_rd[g]   = b.inst_rdata;
        assign data_rd[g]   = b.data_rdata;
        assign halt_o[g]    = b.halt;
        assign hcode[g]     = b.halt_code;
        assign err_o[g]     = b.err;
        assign eaddr[g]     = b.err_addr;
        assign wcnt[g]      = b.wr_count;
        cpu_mem_model #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE),
                        .READ_LATENCY(LAT), .HALT_ADDR(HALTA)) u_dut (
            .clk(clk), .reset(reset), .bus(b));
    end

    int vec = 0;
    int miss = 0;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, g, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m [DEPTH];
    logic [31:0] hi [4];
    logic [31:0] hd [4];
    logic        m_halt, m_err;
    logic [31:0] m_code, m_eaddr;
    logic [15:0] m_cnt;

    function automatic logic inr(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) / 4 < DEPTH);
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return inr(a) ? m[(a - BASE) / 4] : 32'h0;
    endfunction

    function automatic int lat(input int g);
        return (g == 0) ? 1 : (g == 1) ? 3 : 4;
    endfunction

    task automatic model_step();
        logic [31:0] iv, dv, w;
        logic        ev_d, ev_i, do_wr;
        iv = rd(inst_addr);
        dv = rd(data_addr);
        ev_d = 1'b0;
        do_wr = 1'b0;
        if (reset) begin
            for (int k = 0; k < 4; k++) begin hi[k] = 0; hd[k] = 0; end
            m_halt = 0; m_code = 0; m_err = 0; m_eaddr = 0; m_cnt = 0;
        end else begin
            for (int k = 3; k > 0; k--) begin hi[k] = hi[k-1]; hd[k] = hd[k-1]; end
            hi[0] = iv;
            hd[0] = dv;
            if (data_we != 0 && !m_halt) begin
                if (data_addr == HALTA) begin
                    m_halt = 1; m_code = data_wdata;
                end else if (inr(data_addr)) begin
                    do_wr = 1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
                end else ev_d = 1;
            end
            ev_i = inst_addr[1:0] != 0;
            if (!m_err && (ev_d || ev_i)) begin
                m_err = 1;
                m_eaddr = ev_d ? data_addr : inst_addr;
            end
        end
        if (load_en && inr(load_addr)) m[(load_addr - BASE) / 4] = load_data;
        if (do_wr) begin
            w = m[(data_addr - BASE) / 4];
            for (int b = 0; b < 4; b++)
                if (data_we[b]) w[8*b +: 8] = data_wdata[8*b +: 8];
            m[(data_addr - BASE) / 4] = w;
        end
    endtask

    // Single compare process: model advances on the edge, DUTs checked 1ns later.
    always @(posedge clk) begin
        model_step();
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("inst_rdata", g, inst_rd[g], hi[lat(g)-1]);
            chk("data_rdata", g, data_rd[g], hd[lat(g)-1]);
            chk("halt",       g, {31'b0, halt_o[g]}, {31'b0, m_halt});
            chk("halt_code",  g, hcode[g], m_code);
            chk("err",        g, {31'b0, err_o[g]}, {31'b0, m_err});
            chk("err_addr",   g, eaddr[g], m_eaddr);
            chk("wr_count",   g, {16'b0, wcnt[g]}, {16'b0, m_cnt});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1; inst_addr = 0; data_addr = 32'h200; data_wdata = 32'hBAD;
        data_we = 4'hF; load_en = 0; load_addr = 0; load_data = 0;
        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1; load_addr = i * 4; load_data = 0;
            tick();
        end
        load_addr = 32'h0; load_data = 32'h00300293; tick();
        load_addr = 32'h4; load_data = 32'h00310313; tick();
        load_addr = 32'h8; load_data = 32'h006282b3; tick();
        load_addr = 32'h0001_0000; load_data = 32'hFFFF_FFFF; tick();
        chk("reset wr_count", 0, {16'b0, wcnt[0]}, 32'h0);
        chk("reset inst_rdata", 2, inst_rd[2], 32'h0);
        load_en = 0; data_we = 0;

        // fetch stream, back-to-back
        reset = 0; inst_addr = 32'h0; tick();
        chk("fetch0 L1", 0, inst_rd[0], 32'h00300293);
        chk("reset-store ignored", 0, data_rd[0], 32'h0);
        inst_addr = 32'h4; tick();
        chk("fetch4 L1", 0, inst_rd[0], 32'h00310313);
        inst_addr = 32'h8; tick();
        chk("fetch8 L1", 0, inst_rd[0], 32'h006282b3);
        chk("fetch0 L3", 1, inst_rd[1], 32'h00300293);
        tick();
        chk("fetch4 L3", 1, inst_rd[1], 32'h00310313);
        tick();
        chk("fetch8 L3", 1, inst_rd[1], 32'h006282b3);

        // byte-enabled stores
        data_addr = 32'h100; data_wdata = 32'hAABBCCDD; data_we = 4'hF; tick();
        data_wdata = 32'h11223344; data_we = 4'b0101; tick();
        data_we = 0; data_addr = 32'h102; tick();
        chk("byte merge", 0, data_rd[0], 32'hAA22CC44);
        chk("wr_count 2", 0, {16'b0, wcnt[0]}, 32'h2);

        // read-before-write
        data_addr = 32'h100; data_wdata = 32'h55667788; data_we = 4'hF; tick();
        chk("rbw old", 0, data_rd[0], 32'hAA22CC44);
        data_we = 0; tick();
        chk("rbw new", 0, data_rd[0], 32'h55667788);

        // loader/store collision
        data_addr = 32'h104; data_wdata = 32'hFFFFAABB; data_we = 4'b0011;
        load_en = 1; load_addr = 32'h104; load_data = 32'h12345678; tick();
        load_en = 0; data_we = 0; tick();
        chk("collision", 0, data_rd[0], 32'h1234AABB);

        // out-of-range store, then misaligned fetch
        data_addr = 32'h0001_0000; data_wdata = 32'h5; data_we = 4'hF; tick();
        chk("err set", 0, {31'b0, err_o[0]}, 32'h1);
        chk("err_addr", 0, eaddr[0], 32'h0001_0000);
        data_we = 0; inst_addr = 32'h6; tick();
        inst_addr = 32'h0; tick();
        chk("err_addr kept", 0, eaddr[0], 32'h0001_0000);
        chk("oor read", 0, data_rd[0], 32'h0);

        // halt mailbox
        data_addr = HALTA; data_wdata = 32'h1; data_we = 4'hF; tick();
        chk("halt", 0, {31'b0, halt_o[0]}, 32'h1);
        chk("halt_code", 0, hcode[0], 32'h1);
        chk("halt count", 0, {16'b0, wcnt[0]}, 32'h4);
        data_wdata = 32'h2; tick();
        data_addr = 32'h100; data_wdata = 32'hDEAD; tick();
        data_we = 0; tick();
        chk("frozen mem", 0, data_rd[0], 32'h55667788);
        chk("frozen code", 0, hcode[0], 32'h1);
        chk("frozen count", 0, {16'b0, wcnt[0]}, 32'h4);

        // reset with reads in flight
        data_addr = 32'h104;
        inst_addr = 32'h0; tick();
        inst_addr = 32'h4; tick();
        inst_addr = 32'h8; reset = 1; tick();
        chk("rst inst L4", 2, inst_rd[2], 32'h0);
        chk("rst data L4", 2, data_rd[2], 32'h0);
        chk("rst halt", 2, {31'b0, halt_o[2]}, 32'h0);
        chk("rst err", 2, {31'b0, err_o[2]}, 32'h0);
        reset = 0; inst_addr = 32'h4; tick();
        chk("post-rst L4 empty", 2, inst_rd[2], 32'h0);
        inst_addr = 32'h0; tick(); tick(); tick();
        chk("post-rst L4 fetch", 2, inst_rd[2], 32'h00310313);
        chk("post-rst L4 data", 2, data_rd[2], 32'h1234AABB);
        data_addr = 32'h108; data_wdata = 32'hCAFEF00D; data_we = 4'hF; tick();
        data_we = 0; tick();
        chk("store after rst", 0, {16'b0, wcnt[0]}, 32'h1);

        // misaligned fetch as first error
        reset = 1; tick();
        reset = 0; inst_addr = 32'h6; tick();
        chk("inst err addr", 0, eaddr[0], 32'h6);

        // simultaneous inst and data errors
        reset = 1; inst_addr = 32'h0; tick();
        reset = 0; inst_addr = 32'h2; data_addr = 32'h0002_0000; data_we = 4'hF; tick();
        chk("dual err addr", 1, eaddr[1], 32'h0002_0000);
        data_we = 0; inst_addr = 32'h0; data_addr = 32'h108; tick(); tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
